seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative unsigned restoring divider for the Gumnut ALU datapath.
- Performs the inverse of the adder's operation: a repeated trial subtract with borrow. It produces quotient and remainder one bit per clock.
- Sits beside the combinational 8-bit adder. Sequenced by a start/busy/done handshake from the core control unit.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
- clk_i  input  1  system clock, rising edge
- rst_ni  input  1  reset, asynchronous assert, active-low
- start_i  input  1  request a division; sampled only when not busy
- dividend_i  input  WIDTH  numerator, captured on the accepted start edge
- divisor_i  input  WIDTH  denominator, captured on the accepted start edge
- busy_o  output  1  high while a division is in progress
- done_o  output  1  high when results are valid; held until the next accepted start
- quotient_o  output  WIDTH  quotient
- remainder_o  output  WIDTH  remainder
- dz_o  output  1  divide-by-zero flag, valid with done_o

Behaviour:
- Interface: one clock `clk_i`. Reset `rst_ni` is asynchronous and active-low.
- Reset values: busy_o=0, done_o=0, quotient_o=0, remainder_o=0, dz_o=0, state=IDLE, counter=0.
- FSM states:
  - IDLE: busy_o=0. On start_i=1 at edge k:
    - Capture operands.
    - Clear done_o and dz_o.
    - If divisor_i==0, go to DONE.
    - Otherwise go to RUN, set busy_o=1 and counter=0.
  - RUN: one iteration per edge.
    - Shift the partial remainder left by 1, bringing in the dividend MSB.
    - Trial-subtract the divisor (WIDTH+1-bit subtract, borrow out).
    - No borrow: keep the difference and shift 1 into the quotient. Borrow: restore (keep the shifted value) and shift 0 into the quotient.
    - After WIDTH iterations, go to DONE.
  - DONE: done_o=1, busy_o=0, results stable. start_i=1 is accepted exactly as in IDLE.
- Latency:
  - Nonzero divisor: start accepted at edge k, then busy_o=1 after edges k .. k+WIDTH-1. done_o=1 and results valid after edge k+WIDTH, which is 8 cycles for WIDTH=8.
  - Zero divisor: done_o=1 after edge k+1.
- Divide-by-zero results: quotient_o = all ones, remainder_o = dividend, dz_o=1.
- Arithmetic: unsigned only. The partial remainder is WIDTH+1 bits internally, and the final remainder is always < divisor.
- Outputs during RUN: quotient_o and remainder_o may show intermediate values. Consumers must qualify on done_o.
- Boundary conditions:
  - start_i high while busy_o=1: ignored. Captured operands are unchanged and no restart occurs.
  - start_i held high continuously: a new division starts on every cycle the block is in IDLE/DONE, i.e. back-to-back operations. done_o is high for one cycle between them.
  - Inputs changing during RUN: no effect, because operands are captured.
  - dividend < divisor: quotient 0, remainder = dividend, full WIDTH-cycle latency.
  - divisor=1: quotient = dividend, remainder 0.
  - rst_ni low mid-operation: immediate return to IDLE with all outputs at reset values. A division in progress is discarded.

Decomposition:
- Shared include/package `alu_defs`: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2, and the default WIDTH constant.
- One sub-module, `sub_step`: a combinational (WIDTH+1)-bit trial subtractor.
  - Outputs the difference and borrow_o.
  - It is the subtract counterpart of the adder and is reusable by the future SUB/CMP ALU path.

Test Plan:
- Basic division: dividend=100, divisor=7, pulse start → after 8 cycles done_o=1, quotient_o=14, remainder_o=2, dz_o=0; busy_o high exactly 8 cycles.
- Edge operands:
  - 255/1 → q=255, r=0.
  - 7/9 → q=0, r=7.
  - 255/255 → q=1, r=0.
  - Each with 8-cycle latency.
- Divide by zero: dividend=5, divisor=0 → done_o=1 one cycle after start, q=8'hFF, r=8'h05, dz_o=1, busy_o never high.
- Handshake:
  - Start 200/3, then pulse start with 9/2 at cycle 3 while busy → ignored; result q=66, r=2.
  - Then start 9/2 from DONE → q=4, r=1.
- Reset mid-operation: start 100/7, deassert rst_ni at cycle 4 → all outputs 0 immediately. Release, start 50/5 → q=10, r=0.
- Exhaustive sweep: all 256×255 nonzero divisor pairs in back-to-back mode. Check q*divisor+r==dividend and r<divisor for each.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU definitions: divider FSM state encoding and default datapath width.
package alu_defs;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 4;

   // DIVZ is a one-cycle hold so a zero divisor reports done one edge after start.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      DIVZ = 2'd3
   } state_t;

endpackage

// File: rtl/sub_step.sv
// Combinational trial subtractor with borrow out; subtract counterpart of the ALU adder.
module sub_step #(
   parameter int W = 9
) (
   input  logic [W-1:0] minuend_i,
   input  logic [W-1:0] subtrahend_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_o
);

   assign {borrow_o, diff_o} = {1'b0, minuend_i} - {1'b0, subtrahend_i};

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider
   import alu_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             dz_o
);

   if (WIDTH < 2 || (1 << CNT_W) <= WIDTH) begin : g_bad_param
      $error("seq_divider: need WIDTH >= 2 and 2**CNT_W > WIDTH");
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_dvs;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_dz;

   logic               w_accept;
   logic               w_busy;
   logic               w_done;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_borrow;
   logic               w_unused;

   // r_quo doubles as the dividend shift register: dividend bits leave at the MSB
   // while quotient bits enter at the LSB.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};

   sub_step #(.W(WIDTH + 1)) u_step (
      .minuend_i    (w_shift),
      .subtrahend_i ({1'b0, r_dvs}),
      .diff_o       (w_diff),
      .borrow_o     (w_borrow)
   );

   // A kept difference is below the divisor, so its top bit is always zero.
   assign w_unused = w_diff[WIDTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            w_done = (r_state == DONE);
            if (start_i) begin
               w_accept    = 1'b1;
               w_state_nxt = (divisor_i == '0) ? DIVZ : RUN;
            end
         end
         RUN: begin
            w_busy = 1'b1;
            if (r_cnt == LAST) w_state_nxt = DONE;
         end
         DIVZ:    w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
         r_cnt <= '0;
         r_dz  <= 1'b0;
      end else if (w_accept) begin
         r_dvs <= divisor_i;
         r_cnt <= '0;
         r_dz  <= 1'b0;
         if (divisor_i == '0) begin
            r_quo <= '1;
            r_rem <= dividend_i;
         end else begin
            r_quo <= dividend_i;
            r_rem <= '0;
         end
      end else if (r_state == RUN) begin
         // Restore on borrow: keep the shifted value instead of the difference.
         r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
         r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == DIVZ) begin
         r_dz <= 1'b1;
      end
   end

   assign busy_o      = w_busy;
   assign done_o      = w_done;
   assign quotient_o  = r_quo;
   assign remainder_o = r_rem;
   assign dz_o        = r_dz;

endmodule
